// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard and optional
// same-cycle write->read forwarding; contents are zeroed by a post-reset sweep.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ready_o,
  input  logic [NREAD*AW-1:0]      rs_i,
  output logic [NREAD*XLEN-1:0]    xrs_o,
  output logic [NREAD-1:0]         rs_busy_o,
  input  logic [NWRITE-1:0]        we_i,
  input  logic [NWRITE*AW-1:0]     rd_i,
  input  logic [NWRITE*XLEN-1:0]   wdata_i,
  input  logic                     issue_i,
  input  logic [AW-1:0]            issue_rd_i
);

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   ram_q [NREGS];
  logic              ready_s;
  logic [NREAD*XLEN-1:0] xrs_s;
  logic [NREAD-1:0]  rs_busy_s;

  assign ready_s   = (state_q == S_RUN);
  assign ready_o   = ready_s;
  assign xrs_o     = xrs_s;
  assign rs_busy_o = rs_busy_s;

  // State, sweep index and scoreboard registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      idx_q   <= AW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Init sweep sequencing; RUN is left only through reset
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = S_RUN;
        end else begin
          state_d = S_INIT;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Array storage: sweep zeroes entries 1..NREGS-1; later ports override earlier ones
  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) begin
      ram_q[idx_q] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (we_i[k] && (rd_i[k*AW +: AW] != '0)) begin
          ram_q[rd_i[k*AW +: AW]] <= wdata_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: writes clear, a same-cycle issue re-marks busy
  always_comb begin
    busy_d = busy_q;
    if (ready_s) begin
      for (int k = 0; k < NWRITE; k++) begin
        busy_d[rd_i[k*AW +: AW]] = busy_d[rd_i[k*AW +: AW]] & ~we_i[k];
      end
      busy_d[issue_rd_i] = busy_d[issue_rd_i] | issue_i;
    end else begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Combinational read ports with optional forwarding of same-cycle writes
  always_comb begin
    logic [AW-1:0] ra;
    logic          hit;
    xrs_s     = '0;
    rs_busy_s = '0;
    ra        = '0;
    hit       = 1'b0;
    for (int j = 0; j < NREAD; j++) begin
      ra = rs_i[j*AW +: AW];
      if (ready_s && (ra != '0)) begin
        xrs_s[j*XLEN +: XLEN] = ram_q[ra];
        rs_busy_s[j]          = busy_q[ra];
        for (int k = 0; k < NWRITE; k++) begin
          hit = (BYPASS == 1'b1) && we_i[k] && (rd_i[k*AW +: AW] == ra);
          xrs_s[j*XLEN +: XLEN] = hit ? wdata_i[k*XLEN +: XLEN] : xrs_s[j*XLEN +: XLEN];
          rs_busy_s[j]          = rs_busy_s[j] & ~hit;
        end
      end else begin
        xrs_s[j*XLEN +: XLEN] = '0;
        rs_busy_s[j]          = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one forwarding and one non-forwarding
// instance share all inputs; expectations are queued and checked at negedge.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam int K_RDY = 0, K_XA0 = 1, K_XA1 = 2, K_BA0 = 3, K_BA1 = 4,
                 K_XB0 = 5, K_BB0 = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2*AW-1:0]   rs_v;
  logic [1:0]        we_v;
  logic [2*AW-1:0]   rd_v;
  logic [2*XLEN-1:0] wdata_v;
  logic              issue_v;
  logic [AW-1:0]     issue_rd_v;

  logic              ready_a, ready_b;
  logic [2*XLEN-1:0] xrs_a, xrs_b;
  logic [1:0]        busy_a, busy_b;

  regfile_mp #(.BYPASS(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .ready_o(ready_a), .rs_i(rs_v), .xrs_o(xrs_a),
    .rs_busy_o(busy_a), .we_i(we_v), .rd_i(rd_v), .wdata_i(wdata_v),
    .issue_i(issue_v), .issue_rd_i(issue_rd_v)
  );

  regfile_mp #(.BYPASS(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .ready_o(ready_b), .rs_i(rs_v), .xrs_o(xrs_b),
    .rs_busy_o(busy_b), .we_i(we_v), .rd_i(rd_v), .wdata_i(wdata_v),
    .issue_i(issue_v), .issue_rd_i(issue_rd_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   errors  = 0;
  int   checks  = 0;
  event sample_ev;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] actual_of(int kind);
    case (kind)
      K_RDY:   return {30'd0, ready_b, ready_a};
      K_XA0:   return xrs_a[31:0];
      K_XA1:   return xrs_a[63:32];
      K_BA0:   return {31'd0, busy_a[0]};
      K_BA1:   return {31'd0, busy_a[1]};
      K_XB0:   return xrs_b[31:0];
      K_BB0:   return {31'd0, busy_b[0]};
      default: return 32'hDEAD_0BAD;
    endcase
  endfunction

  // Monitor: pops every expectation due by now and compares against the DUTs
  initial begin
    exp_t        t;
    logic [31:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        t   = q.pop_front();
        act = actual_of(t.kind);
        checks++;
        if (act !== t.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", t.name, act, t.exp, cyc_cnt);
        end
      end
    end
  end

  task automatic exp_push(int kind, logic [31:0] e, string nm);
    exp_t t;
    t.cyc  = cyc_cnt;
    t.kind = kind;
    t.exp  = e;
    t.name = nm;
    q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_v       = 2'b00;
    rd_v       = '0;
    wdata_v    = '0;
    issue_v    = 1'b0;
    issue_rd_v = 5'd0;
  endtask

  task automatic wr(int k, logic [4:0] r, logic [31:0] d);
    we_v[k]              = 1'b1;
    rd_v[k*AW +: AW]     = r;
    wdata_v[k*XLEN +: XLEN] = d;
  endtask

  task automatic rs_set(logic [4:0] a, logic [4:0] b);
    rs_v = {b, a};
  endtask

  initial begin
    idle();
    rs_set(5'd5, 5'd0);
    #2;
    // Reset state
    exp_push(K_RDY, 32'd0, "rst_ready");
    exp_push(K_XA0, 32'd0, "rst_xrs");
    exp_push(K_BA0, 32'd0, "rst_busy");
    step();
    step();
    rst = 1'b0;

    // T1: sweep length, writes/issues ignored while not ready
    wr(0, 5'd3, 32'h0000_0055);
    issue_v    = 1'b1;
    issue_rd_v = 5'd4;
    rs_set(5'd3, 5'd4);
    for (int i = 0; i < 31; i++) begin
      exp_push(K_RDY, 32'd0, "sweep_ready_low");
      exp_push(K_XA0, 32'd0, "sweep_xrs_zero");
      exp_push(K_BA1, 32'd0, "sweep_busy_zero");
      step();
    end
    idle();
    exp_push(K_RDY, 32'd3, "sweep_ready_high");
    exp_push(K_XA0, 32'd0, "init_write_dropped");
    exp_push(K_BA1, 32'd0, "init_issue_dropped");
    step();
    for (int i = 0; i < 16; i++) begin
      rs_set(5'(2*i), 5'(2*i+1));
      exp_push(K_XA0, 32'd0, "sweep_zero_p0");
      exp_push(K_XA1, 32'd0, "sweep_zero_p1");
      exp_push(K_XB0, 32'd0, "sweep_zero_b");
      step();
    end

    // T2: both ports write x5, highest port wins
    idle();
    wr(0, 5'd5, 32'h1111_1111);
    wr(1, 5'd5, 32'hAAAA_0000);
    rs_set(5'd5, 5'd0);
    exp_push(K_XA0, 32'hAAAA_0000, "t2_fwd_highest");
    exp_push(K_XB0, 32'd0,         "t2_nobyp_old");
    step();
    idle();
    rs_set(5'd5, 5'd0);
    exp_push(K_XA0, 32'hAAAA_0000, "t2_stored_a");
    exp_push(K_XB0, 32'hAAAA_0000, "t2_stored_b");
    step();

    // T3: forwarding of x7 over a pending producer
    idle();
    issue_v    = 1'b1;
    issue_rd_v = 5'd7;
    rs_set(5'd7, 5'd0);
    exp_push(K_BA0, 32'd0, "t3_busy_pre");
    step();
    idle();
    wr(0, 5'd7, 32'hDEAD_BEEF);
    rs_set(5'd7, 5'd0);
    exp_push(K_XA0, 32'hDEAD_BEEF, "t3_fwd_data");
    exp_push(K_BA0, 32'd0,         "t3_fwd_busy");
    exp_push(K_XB0, 32'd0,         "t3_nobyp_old");
    exp_push(K_BB0, 32'd1,         "t3_nobyp_busy");
    step();
    idle();
    rs_set(5'd7, 5'd0);
    exp_push(K_XA0, 32'hDEAD_BEEF, "t3_stored_a");
    exp_push(K_XB0, 32'hDEAD_BEEF, "t3_stored_b");
    exp_push(K_BB0, 32'd0,         "t3_busy_cleared");
    step();

    // T4: scoreboard set / clear / issue-over-write
    idle();
    issue_v    = 1'b1;
    issue_rd_v = 5'd9;
    rs_set(5'd9, 5'd0);
    exp_push(K_BA0, 32'd0, "t4_not_yet");
    step();
    idle();
    rs_set(5'd9, 5'd0);
    exp_push(K_BA0, 32'd1, "t4_busy_set_a");
    exp_push(K_BB0, 32'd1, "t4_busy_set_b");
    step();
    idle();
    wr(0, 5'd9, 32'h0000_0099);
    rs_set(5'd9, 5'd0);
    exp_push(K_BA0, 32'd0, "t4_fwd_unbusy");
    exp_push(K_BB0, 32'd1, "t4_nobyp_busy");
    exp_push(K_XB0, 32'd0, "t4_nobyp_old");
    step();
    idle();
    rs_set(5'd9, 5'd0);
    exp_push(K_BB0, 32'd0,          "t4_write_clears");
    exp_push(K_XA0, 32'h0000_0099, "t4_stored");
    step();
    idle();
    issue_v    = 1'b1;
    issue_rd_v = 5'd9;
    wr(1, 5'd9, 32'h0000_0123);
    rs_set(5'd9, 5'd0);
    step();
    idle();
    rs_set(5'd9, 5'd10);
    exp_push(K_BA0, 32'd1,          "t4_issue_wins_a");
    exp_push(K_BB0, 32'd1,          "t4_issue_wins_b");
    exp_push(K_BA1, 32'd0,          "t4_other_reg_idle");
    exp_push(K_XA0, 32'h0000_0123, "t4_write_landed");
    step();

    // T5: register x0
    idle();
    wr(0, 5'd0, 32'h1234_5678);
    issue_v    = 1'b1;
    issue_rd_v = 5'd0;
    rs_set(5'd0, 5'd0);
    exp_push(K_XA0, 32'd0, "t5_no_fwd_x0");
    exp_push(K_BA0, 32'd0, "t5_busy_x0_now");
    step();
    idle();
    rs_set(5'd0, 5'd9);
    exp_push(K_XA0, 32'd0, "t5_x0_zero_a");
    exp_push(K_XB0, 32'd0, "t5_x0_zero_b");
    exp_push(K_BA0, 32'd0, "t5_x0_not_busy");
    exp_push(K_BA1, 32'd1, "t5_x9_still_busy");
    step();

    // T6: asynchronous reset mid-cycle
    idle();
    rs_set(5'd9, 5'd5);
    exp_push(K_BA0, 32'd1,          "t6_busy_before");
    exp_push(K_XA1, 32'hAAAA_0000, "t6_x5_before");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_push(K_RDY, 32'd0, "t6_ready_drop");
    exp_push(K_BA0, 32'd0, "t6_busy_drop_a");
    exp_push(K_BB0, 32'd0, "t6_busy_drop_b");
    exp_push(K_XA1, 32'd0, "t6_xrs_drop");
    -> sample_ev;
    step();
    rst = 1'b0;
    exp_push(K_RDY, 32'd0, "t6_sweep_start");
    for (int i = 0; i < 30; i++) step();
    exp_push(K_RDY, 32'd0, "t6_sweep_last");
    step();
    exp_push(K_RDY, 32'd3, "t6_ready_again");
    exp_push(K_XA1, 32'd0, "t6_x5_zeroed");
    exp_push(K_BA0, 32'd0, "t6_busy_cleared");
    step();
    step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
